pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the team's single-cycle combinational CLA.
- The operand is split into BLOCK-bit slices, one slice per pipeline stage. Each stage uses carry-lookahead internally and registers its carry out to the next stage.
- Adds carry-in, subtract mode, signed overflow and a valid/ready handshake with backpressure.
- Sits in the datapath between the operand-fetch stage and result writeback.

---
 rtl/pipelined_cla_adder.sv | 172 +++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead slice per stage, valid/ready flow control.
// Optional signed saturation is enabled by defining PIPELINED_CLA_ADDER_SAT_EN (adds the i_sat port).
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_cin,
    input  logic             i_sub,
`ifdef PIPELINED_CLA_ADDER_SAT_EN
    input  logic             i_sat,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_ovf
);

    localparam int STAGES = WIDTH / BLOCK;

    // Each carry is a flat sum of products over the slice, so no carry ripples bit to bit.
    function automatic logic [BLOCK:0] cla_carries(
        input logic [BLOCK-1:0] g,
        input logic [BLOCK-1:0] p,
        input logic             cin
    );
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             ovf_q;

    logic             v_d   [STAGES];
    logic             c_d   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             ovf_d;

    logic             v_src [STAGES];
    logic             c_src [STAGES];
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];

`ifdef PIPELINED_CLA_ADDER_SAT_EN
    logic             sat_q   [STAGES];
    logic             sat_d   [STAGES];
    logic             sat_src [STAGES];
`endif

    logic [BLOCK-1:0] a_sl;
    logic [BLOCK-1:0] b_sl;
    logic [BLOCK:0]   cv;
    logic             stall;

    assign stall    = v_q[STAGES-1] & ~i_ready;
    assign o_ready  = ~stall;
    assign o_valid  = v_q[STAGES-1];
    assign o_result = {c_q[STAGES-1], s_q[STAGES-1]};
    assign o_ovf    = ovf_q;

    // Stage 0 is fed from the ports; stage k is fed from the registers of stage k-1.
    always_comb begin
        a_src[0] = i_add1;
        b_src[0] = i_sub ? ~i_add2 : i_add2;
        s_src[0] = '0;
        c_src[0] = i_sub | i_cin;
        v_src[0] = i_valid;
`ifdef PIPELINED_CLA_ADDER_SAT_EN
        sat_src[0] = i_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
`ifdef PIPELINED_CLA_ADDER_SAT_EN
            sat_src[k] = sat_q[k-1];
`endif
        end
    end

    always_comb begin
        ovf_d = 1'b0;
        a_sl  = '0;
        b_sl  = '0;
        cv    = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_sl   = a_src[k][k*BLOCK +: BLOCK];
            b_sl   = b_src[k][k*BLOCK +: BLOCK];
            cv     = cla_carries(a_sl & b_sl, a_sl ^ b_sl, c_src[k]);
            a_d[k] = a_src[k];
            b_d[k] = b_src[k];
            v_d[k] = v_src[k];
            c_d[k] = cv[BLOCK];
            s_d[k] = s_src[k];
            s_d[k][k*BLOCK +: BLOCK] = a_sl ^ b_sl ^ cv[BLOCK-1:0];
`ifdef PIPELINED_CLA_ADDER_SAT_EN
            sat_d[k] = sat_src[k];
`endif
            if (k == STAGES - 1) begin
                ovf_d = cv[BLOCK] ^ cv[BLOCK-1];
`ifdef PIPELINED_CLA_ADDER_SAT_EN
                // On overflow both operands share the sign of A, which picks the clamp direction.
                if (sat_src[k] && ovf_d) begin
                    s_d[k] = a_sl[BLOCK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
                    c_d[k] = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
`ifdef PIPELINED_CLA_ADDER_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
`ifdef PIPELINED_CLA_ADDER_SAT_EN
                sat_q[k] <= sat_d[k];
`endif
            end
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=32, BLOCK=8): vector table, stream/stall/reset sequences,
// and random traffic scored against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_pipelined_cla_adder;
    localparam int W   = 32;
    localparam int STG = 4;
`ifdef PIPELINED_CLA_ADDER_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         ds_ready = 1'b1;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         sat = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_ready;
    logic         out_valid;
    logic         ovf;
    logic [W:0]   result;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    pipelined_cla_adder #(.WIDTH(W), .BLOCK(8)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_add1   (a),
        .i_add2   (b),
        .i_cin    (cin),
        .i_sub    (sub),
`ifdef PIPELINED_CLA_ADDER_SAT_EN
        .i_sat    (sat),
`endif
        .o_valid  (out_valid),
        .i_ready  (ds_ready),
        .o_result (result),
        .o_ovf    (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic; signed overflow = true result outside 32-bit signed range.
    function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                           input logic c, input logic s, input logic st);
        logic [W:0] r;
        longint     sa, sbv, sr;
        logic       ov;
        sa  = longint'($signed(aa));
        sbv = longint'($signed(bb));
        if (s) begin
            r     = {1'b0, aa} - {1'b0, bb};
            r[W]  = ~r[W];
            sr    = sa - sbv;
        end else begin
            r  = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c};
            sr = sa + sbv + longint'(c);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (SAT_BUILD && st && ov)
            r = {1'b0, aa[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF};
        return {ov, r};
    endfunction

    typedef struct {
        logic [W:0] res;
        logic       ovf;
        int         acc_cyc;
        int         acc_stalls;
    } exp_t;

    exp_t       exp_q[$];
    int         stall_cnt = 0;
    int         pushed = 0;
    int         popped = 0;
    bit         prev_stall = 1'b0;
    logic [W:0] held_res = '0;
    logic       held_ovf = 1'b0;

    always @(negedge clk) begin
        bit          stall_now;
        exp_t        e;
        logic [W+1:0] m;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            stall_now = out_valid && !ds_ready;
            chk("o_ready_vs_stall", {63'd0, out_ready}, {63'd0, !stall_now});
            if (out_valid) begin
                if (prev_stall) begin
                    chk("held_result", result, held_res);
                    chk("held_ovf", ovf, held_ovf);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_o_valid", out_valid, 1'b0);
                end else begin
                    e = exp_q[0];
                    chk("sb_result", result, e.res);
                    chk("sb_ovf", ovf, e.ovf);
                    chk("sb_latency", cyc, e.acc_cyc + STG + stall_cnt - e.acc_stalls);
                end
                if (!stall_now && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
                held_res = result;
                held_ovf = ovf;
            end
            if (in_valid && out_ready) begin
                m            = model(a, b, cin, sub, sat);
                e.res        = m[W:0];
                e.ovf        = m[W+1];
                e.acc_cyc    = cyc;
                e.acc_stalls = stall_cnt;
                exp_q.push_back(e);
                pushed++;
            end
            if (stall_now) stall_cnt++;
            prev_stall = stall_now;
        end
    end

    // Called at the start of a cycle; holds the beat until it is taken, returns one cycle after.
    task automatic drive_beat(input logic [W-1:0] aa, input logic [W-1:0] bb,
                              input logic c, input logic s, input logic st);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        a = aa; b = bb; cin = c; sub = s; sat = st;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            done = out_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W:0]   res;
        logic         ovf;
    } vec_t;

    vec_t       tbl[12];
    logic [W:0] got_res[8];
    int         got_cyc[8];
    int         got_n;
    int         lat, c0, s0, p0;
    bit         acc;

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0};
        tbl[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 33'h0_FFFF_FFFE, 1'b0};
        tbl[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 33'h1_7FFF_FFFF, 1'b1};
        tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1};
        tbl[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 33'h0_0000_0001, 1'b0};
        tbl[5]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 33'h1_0000_0007, 1'b0};
        tbl[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF, 1'b0};
        tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33'h1_0000_0000, 1'b1};
        tbl[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 33'h1_0000_0000, 1'b0};
        tbl[9]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0100, 1'b0};
        tbl[10] = '{32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 33'h0_0100_0000, 1'b0};
        tbl[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 33'h0_8000_0000, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_valid", out_valid, 1'b0);
        chk("reset_o_ready", out_ready, 1'b1);
        chk("reset_o_result", result, '0);
        chk("reset_o_ovf", ovf, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            drive_beat(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b0);
            wait_out(lat);
            chk($sformatf("vec%0d_latency", i), lat, STG);
            chk($sformatf("vec%0d_result", i), result, tbl[i].res);
            chk($sformatf("vec%0d_ovf", i), ovf, tbl[i].ovf);
        end
        @(posedge clk); #1;

        // Back-to-back beats (n, n, cin=1) must emerge on consecutive cycles.
        c0    = cyc;
        got_n = 0;
        fork
            begin
                for (int n = 0; n < 8; n++) drive_beat(32'(n), 32'(n), 1'b1, 1'b0, 1'b0);
            end
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (out_valid && ds_ready && got_n < 8) begin
                        got_res[got_n] = result;
                        got_cyc[got_n] = cyc;
                        got_n++;
                    end
                end
            end
        join
        chk("b2b_count", got_n, 8);
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("b2b%0d_result", n), got_res[n], 33'(2 * n + 1));
            chk($sformatf("b2b%0d_cycle", n), got_cyc[n], c0 + STG + n);
        end
        @(posedge clk); #1;

        // Backpressure: drop i_ready for three cycles once results start flowing.
        s0 = stall_cnt;
        p0 = popped;
        fork
            begin
                for (int n = 0; n < 6; n++)
                    drive_beat(32'h0100_0000 * (n + 1) + 32'(n), 32'h00FF_FFFF ^ 32'(n), 1'b0, 1'(n % 2), 1'b0);
            end
            begin
                for (int t = 0; t < 40 && !out_valid; t++) begin
                    @(posedge clk); #1;
                end
                @(posedge clk); #1;
                ds_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                end
                ds_ready = 1'b1;
            end
        join
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("bp_stall_cycles", stall_cnt - s0, 3);
        chk("bp_results", popped - p0, 6);
        chk("bp_drained", exp_q.size(), 0);

        // Random traffic with random backpressure; upstream holds a beat until it is taken.
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ds_ready = ($urandom_range(0, 4) != 0);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a        = rnd_op();
                b        = rnd_op();
                cin      = 1'($urandom_range(0, 1));
                sub      = 1'($urandom_range(0, 1));
                sat      = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            acc = in_valid && out_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ds_ready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_in_out_balance", popped, pushed);

`ifdef PIPELINED_CLA_ADDER_SAT_EN
        drive_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        chk("sat_on_result", result, 33'h0_7FFF_FFFF);
        chk("sat_on_ovf", ovf, 1'b1);
        drive_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        chk("sat_off_result", result, 33'h0_8000_0000);
        chk("sat_off_ovf", ovf, 1'b1);
        drive_beat(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        wait_out(lat);
        chk("sat_neg_result", result, 33'h0_8000_0000);
        @(posedge clk); #1;
`endif

        // Reset with three beats in flight: nothing may come out afterwards.
        for (int n = 0; n < 3; n++) drive_beat(32'h1234_0000 + 32'(n), 32'h1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_o_valid", out_valid, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_o_valid", out_valid, 1'b0);
        chk("rst_async_o_result", result, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rel_o_valid", out_valid, 1'b0);
        chk("rst_rel_o_ready", out_ready, 1'b1);
        chk("rst_rel_o_result", result, '0);
        chk("rst_rel_o_ovf", ovf, 1'b0);
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            chk("rst_no_stale", out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
